// File: rtl/bypass_regfile.sv
// Register file with in-flight writer tracking, forwarding and load-use interlock; reads are combinational.
// NCORE_BYPASS_EN enables forwarding; without it any matching in-flight writer stalls the reader until retire.
module bypass_regfile #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int NREAD = 2,
  parameter int DEPTH = 3,
  localparam int AW = $clog2(NREG),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREAD-1:0]        rd_en,
  input  logic [NREAD*AW-1:0]     rd_addr,
  output logic [NREAD*XLEN-1:0]   rd_data,
  output logic                    rd_stall,
  input  logic                    issue_valid,
  input  logic                    issue_wen,
  input  logic [AW-1:0]           issue_waddr,
  input  logic [LW-1:0]           issue_lat,
  input  logic [DEPTH*XLEN-1:0]   res_data,
  input  logic                    stall,
  input  logic                    hold,
  input  logic [DEPTH-1:0]        kill_mask,
  output logic                    issue_accept
);

  typedef struct packed {
    logic            valid;
    logic            wen;
    logic [AW-1:0]   waddr;
    logic [LW-1:0]   lat;
    logic [XLEN-1:0] data;
    logic            dvalid;
  } entry_t;

  entry_t          stg [DEPTH];
  entry_t          cap [DEPTH];
  entry_t          nxt [DEPTH];
  entry_t          new_e;
  logic [LW-1:0]   lat_c;
  logic [XLEN-1:0] rf [NREG];
  logic            wr_en;

  logic [AW-1:0]   ra;
  logic [XLEN-1:0] rf_val;
  logic [XLEN-1:0] val;
  logic            blk;

  assign issue_accept = issue_valid & ~stall & ~rd_stall & ~hold & ~kill_mask[0];

  // cap[] is each stage after this edge's result capture, which happens even under hold
  always_comb begin
    lat_c = (issue_lat > LW'(DEPTH)) ? LW'(DEPTH) : issue_lat;
    new_e = '0;
    new_e.valid = issue_accept;
    new_e.wen   = issue_wen && (issue_waddr != '0) && (lat_c != '0);
    new_e.waddr = issue_waddr;
    new_e.lat   = lat_c;
    for (int s = 0; s < DEPTH; s++) begin
      cap[s] = stg[s];
      if (stg[s].valid && !stg[s].dvalid && stg[s].lat == LW'(s + 1)) begin
        cap[s].data   = res_data[s*XLEN +: XLEN];
        cap[s].dvalid = 1'b1;
      end
    end
    nxt[0] = hold ? cap[0] : new_e;
    for (int s = 1; s < DEPTH; s++) begin
      nxt[s] = hold ? cap[s] : cap[s-1];
    end
    for (int s = 0; s < DEPTH; s++) begin
      if (kill_mask[s]) nxt[s].valid = 1'b0;
    end
  end

  assign wr_en = !hold && cap[DEPTH-1].valid && cap[DEPTH-1].wen && cap[DEPTH-1].dvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) stg[s] <= '0;
      for (int r = 0; r < NREG; r++) rf[r] <= '0;
    end else begin
      for (int s = 0; s < DEPTH; s++) stg[s] <= nxt[s];
      if (wr_en) rf[cap[DEPTH-1].waddr] <= cap[DEPTH-1].data;
    end
  end

  // Scan oldest to youngest so the lowest matching stage has the final say
  always_comb begin
    rd_stall = 1'b0;
    rd_data  = '0;
    ra       = '0;
    rf_val   = '0;
    val      = '0;
    blk      = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      ra     = rd_addr[i*AW +: AW];
      rf_val = (ra == '0) ? '0 : rf[ra];
      val    = rf_val;
      blk    = 1'b0;
      for (int s = DEPTH - 1; s >= 0; s--) begin
        if (stg[s].valid && stg[s].wen && stg[s].waddr == ra) begin
`ifdef NCORE_BYPASS_EN
          if (stg[s].dvalid) begin
            val = stg[s].data;
            blk = 1'b0;
          end else if (stg[s].lat == LW'(s + 1)) begin
            val = res_data[s*XLEN +: XLEN];
            blk = 1'b0;
          end else begin
            val = rf_val;
            blk = 1'b1;
          end
`else
          blk = 1'b1;
`endif
        end
      end
      rd_data[i*XLEN +: XLEN] = val;
      if (rd_en[i] && blk) rd_stall = 1'b1;
    end
  end

endmodule

// File: tb/tb_bypass_regfile.sv
// Directed bench for bypass_regfile (DEPTH=3, NREAD=2); expectations follow NCORE_BYPASS_EN when defined.
module tb_bypass_regfile;
  localparam int XLEN = 32, NREG = 32, NREAD = 2, DEPTH = 3, AW = 5, LW = 2;
`ifdef NCORE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREAD-1:0]      rd_en;
  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD*XLEN-1:0] rd_data;
  logic                  rd_stall;
  logic                  issue_valid, issue_wen;
  logic [AW-1:0]         issue_waddr;
  logic [LW-1:0]         issue_lat;
  logic [DEPTH*XLEN-1:0] res_data;
  logic                  stall, hold;
  logic [DEPTH-1:0]      kill_mask;
  logic                  issue_accept;

  bypass_regfile #(.XLEN(XLEN), .NREG(NREG), .NREAD(NREAD), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_stall(rd_stall), .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_waddr(issue_waddr), .issue_lat(issue_lat), .res_data(res_data),
    .stall(stall), .hold(hold), .kill_mask(kill_mask), .issue_accept(issue_accept)
  );

  always #5 clk = ~clk;

  string       q_nm[$];
  logic [31:0] q_d[$];
  logic        q_s[$];
  int          q_a[$];
  int          n_tests = 0, n_fail = 0;
  logic        done = 1'b0, flushed = 1'b0;

  string       m_nm;
  logic [31:0] m_d;
  logic        m_s;
  int          m_a;

  // Monitor: every cycle port 0 is enabled, pop and compare one expectation
  always @(negedge clk) begin
    if (rd_en[0]) begin
      if (q_nm.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_read: got read of x%0d, required no read", rd_addr[4:0]);
      end else begin
        m_nm = q_nm.pop_front(); m_d = q_d.pop_front();
        m_s  = q_s.pop_front();  m_a = q_a.pop_front();
        n_tests++;
        if (rd_data[31:0] !== m_d) begin
          n_fail++;
          $display("FAIL %s data: got %h required %h", m_nm, rd_data[31:0], m_d);
        end
        n_tests++;
        if (rd_stall !== m_s) begin
          n_fail++;
          $display("FAIL %s rd_stall: got %b required %b", m_nm, rd_stall, m_s);
        end
        if (m_a != 2) begin
          n_tests++;
          if (issue_accept !== m_a[0]) begin
            n_fail++;
            $display("FAIL %s issue_accept: got %b required %b", m_nm, issue_accept, m_a[0]);
          end
        end
      end
    end
    if (done && !flushed) begin
      flushed = 1'b1;
      n_tests++;
      if (q_nm.size() != 0) begin
        n_fail++;
        $display("FAIL leftover: got %0d unchecked expectations, required 0", q_nm.size());
      end
    end
  end

  task automatic idle();
    rd_en = '0; rd_addr = '0; issue_valid = 1'b0; issue_wen = 1'b0;
    issue_waddr = '0; issue_lat = '0; res_data = '0; stall = 1'b0;
    hold = 1'b0; kill_mask = '0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    idle();
  endtask

  // acc: 0/1 = expected issue_accept, 2 = not checked
  task automatic rd(input logic [4:0] a, input logic [31:0] d, input logic s, input int acc,
                    input string nm);
    rd_en[0] = 1'b1; rd_addr[4:0] = a;
    q_nm.push_back(nm); q_d.push_back(d); q_s.push_back(s); q_a.push_back(acc);
  endtask

  task automatic iss(input logic [4:0] a, input logic [1:0] lat);
    issue_valid = 1'b1; issue_wen = 1'b1; issue_waddr = a; issue_lat = lat;
  endtask

  task automatic res(input int s, input logic [31:0] d);
    res_data[s*XLEN +: XLEN] = d;
  endtask

  initial begin
    idle(); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rd(1, 0, 0, 0, "reset_x1"); cyc();

    // ALU forward
    iss(5, 1); rd(0, 0, 0, 1, "alu_acc"); cyc();
    res(0, 32'h11); rd(5, BYP ? 32'h11 : 32'h0, !BYP, 0, "alu_s0"); cyc();
    rd(5, BYP ? 32'h11 : 32'h0, !BYP, 2, "alu_s1"); cyc();
    rd(5, BYP ? 32'h11 : 32'h0, !BYP, 2, "alu_s2"); cyc();
    rd(5, 32'h11, 0, 2, "alu_rf"); cyc();

    // Load-use
    iss(6, 2); rd(0, 0, 0, 1, "ld_acc"); cyc();
    issue_valid = 1'b1; rd(6, 0, 1, 0, "ld_use_stall"); cyc();
    res(1, 32'hAB); rd(6, BYP ? 32'hAB : 32'h0, !BYP, 2, "ld_fwd"); cyc();
    rd(6, BYP ? 32'hAB : 32'h0, !BYP, 2, "ld_s2"); cyc();
    rd(6, 32'hAB, 0, 2, "ld_rf"); cyc();

    // Youngest writer wins
    iss(7, 1); rd(0, 0, 0, 1, "yw_acc0"); cyc();
    iss(7, 1); res(0, 32'h1); rd(0, 0, 0, 1, "yw_acc1"); cyc();
    res(0, 32'h2); rd(7, BYP ? 32'h2 : 32'h0, !BYP, 2, "yw_fwd"); cyc();
    rd(7, BYP ? 32'h2 : 32'h0, !BYP, 2, "yw_s1"); cyc();
    rd(7, BYP ? 32'h2 : 32'h1, !BYP, 2, "yw_s2"); cyc();
    rd(7, 32'h2, 0, 2, "yw_rf"); cyc();

    // Kill the younger x8 writer as it moves into stage 1
    iss(8, 1); rd(0, 0, 0, 1, "kl_acc0"); cyc();
    iss(8, 1); res(0, 32'h22); rd(0, 0, 0, 1, "kl_acc1"); cyc();
    res(0, 32'h33); kill_mask = 3'b010; rd(8, BYP ? 32'h33 : 32'h0, !BYP, 2, "kl_pre"); cyc();
    rd(8, BYP ? 32'h22 : 32'h0, !BYP, 2, "kl_s2"); cyc();
    rd(8, 32'h22, 0, 2, "kl_rf"); cyc();
    rd(8, 32'h22, 0, 2, "kl_rf_late"); cyc();
    iss(13, 1); kill_mask = 3'b001; rd(0, 0, 0, 0, "kl_acc_blk"); cyc();
    res(0, 32'h66); rd(13, 0, 0, 2, "kl_blk_x13"); cyc();

    // Hold: capture still happens, nothing moves, nothing issues
    iss(9, 2); rd(0, 0, 0, 1, "hd_acc"); cyc();
    rd(9, 0, 1, 2, "hd_pre"); cyc();
    for (int k = 0; k < 3; k++) begin
      hold = 1'b1; iss(12, 1); res(0, 32'h55);
      res(1, (k == 0) ? 32'h44 : 32'h0);
      rd(9, BYP ? 32'h44 : 32'h0, !BYP, 0, "hd_hold");
      cyc();
    end
    rd(9, BYP ? 32'h44 : 32'h0, !BYP, 2, "hd_s1"); cyc();
    rd(9, BYP ? 32'h44 : 32'h0, !BYP, 2, "hd_s2"); cyc();
    rd(9, 32'h44, 0, 2, "hd_rf"); cyc();
    rd(12, 0, 0, 2, "hd_noissue"); cyc();

    // Writes to x0 are ignored
    iss(0, 1); rd(0, 0, 0, 1, "x0_acc"); cyc();
    res(0, 32'h77); rd(0, 0, 0, 2, "x0_fwd"); cyc();
    cyc(); cyc();
    rd(0, 0, 0, 2, "x0_rf"); cyc();

    // Asynchronous reset mid-cycle with x3 in flight
    iss(1, 1); rd(0, 0, 0, 1, "rs_acc1"); cyc();
    res(0, 32'h9); cyc(); cyc(); cyc();
    rd(1, 32'h9, 0, 2, "rs_x1_pre"); cyc();
    iss(3, 1); rd(0, 0, 0, 1, "rs_acc3"); cyc();
    res(0, 32'h5); rd(1, 0, 0, 2, "rs_async");
    rd_en[1] = 1'b1; rd_addr[9:5] = 5'd3;
    #2 rst = 1'b1;
    @(posedge clk); #1; idle();
    @(posedge clk); #1; rst = 1'b0;
    rd(3, 0, 0, 2, "rs_x3_post"); cyc();
    rd(1, 0, 0, 2, "rs_x1_post"); cyc();

    done = 1'b1;
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bypass_regfile.md
# bypass_regfile

Parametrised integer register file with an integrated in-flight writer scoreboard, operand forwarding network and load-use interlock for an in-order pipeline of configurable depth. It sits between decode and the execute/memory/writeback stages of the fixed-point core. It tracks every issued register writer as it moves down `DEPTH` stages, and for each of `NREAD` read ports it returns the youngest available value or raises a stall. It supersedes hand-coded per-stage bypass muxes and adds variable result latency, per-stage kill and an interlock.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `NREG`, 32, architectural registers; `AW = $clog2(NREG)`
- `NREAD`, 2, read ports
- `DEPTH`, 3, tracked stages after decode (stage 0 = EX, stage `DEPTH-1` = WB); must be ≥ 2
- `LW`, derived, `$clog2(DEPTH+1)`

Ports (flattened arrays: port i or stage s occupies slice `[i*W +: W]`):
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-high
- `rd_en` in NREAD: read port enable
- `rd_addr` in NREAD*AW: read addresses
- `rd_data` out NREAD*XLEN: operand values, combinational
- `rd_stall` out 1: a read needs data not yet produced
- `issue_valid` in 1: decode presents an instruction
- `issue_wen` in 1: instruction writes a register
- `issue_waddr` in AW: destination register
- `issue_lat` in LW: stage count until result exists (1 = ALU, 2 = load); 0 means no result; values > DEPTH clamp to DEPTH
- `res_data` in DEPTH*XLEN: result presented by stage s this cycle
- `stall` in 1: decode stall; injects a bubble into stage 0
- `hold` in 1: cache-miss freeze of all stages
- `kill_mask` in DEPTH: invalidates the entry in stage s at the next edge
- `issue_accept` out 1: instruction entered stage 0

## Operation
- Per-stage entry: `valid, wen, waddr, lat, data, dvalid`. Register r0 reads 0 and is never tracked; `wen` is forced to 0 when `waddr == 0`.
- `issue_accept = issue_valid & !stall & !rd_stall & !hold & !kill_mask[0]`.
- Advance (when `!hold`):
  - stage s+1 ← stage s.
  - Stage 0 ← new entry if `issue_accept`, else bubble (`valid = 0`).
  - Stage `DEPTH-1` retires; it writes the register file if `valid & wen & dvalid`.
- Capture: an entry in stage `lat-1` with `!dvalid` takes `res_data[lat-1]` and sets `dvalid` at the edge. This applies during `hold` as well.
- Kill: `kill_mask[s]` clears `valid` of whatever would occupy stage s after the edge. Kill takes priority over advance, capture and issue.
- Per read port with `rd_en`, select the youngest valid matching writer, where the lowest stage wins:
  - `dvalid` set: forward the latched `data`.
  - Entry sits in its capture stage this cycle: forward `res_data[s]`.
  - Otherwise: assert `rd_stall` and present `rd_data` = register file value (don't care).
  - No matching writer: read the register file.
- Read and write of the same register in one cycle: the in-flight WB entry forwards, so the new value is always returned.

## Timing
- Reset state: all entry `valid = 0`; register file = 0; `rd_data = 0`; `rd_stall = 0`; `issue_accept` is combinational from its inputs.
- `rd_data` and `rd_stall` are combinational from `rd_addr`, `rd_en`, entry state and `res_data`; zero-cycle latency.
- Register file writes commit at the edge on which the WB entry retires and become visible through the register file the next cycle.
- Back-to-back dependency with `lat = 1`: no stall. With `lat = L`: `L-1` stall cycles.
- `hold`: no advance, no register file write, no issue; captures still occur.
- `rst` asserted mid-operation discards all in-flight writers immediately; no partial register file write.

## Configuration
- `NCORE_BYPASS_EN` defined: full forwarding as described above.
- Undefined: no forwarding. Any valid matching in-flight writer asserts `rd_stall`, and `rd_data` always comes from the register file. A dependent instruction waits until the writer has retired.

## Test plan
All scenarios use `DEPTH = 3`, `NREAD = 2`.
- Reset: assert `rst` asynchronously mid-cycle → `rd_data` of x1 = 0 and `rd_stall = 0` immediately. In-flight x3 (`lat = 1`, `res_data[0] = 0x5`) is never written; reading x3 afterwards returns 0.
- ALU forward: issue x5 with `lat = 1` and `res_data[0] = 0x11`. Next cycle read x5 → 0x11, `rd_stall = 0`. Three cycles later the register file x5 = 0x11.
- Load-use: issue x6 with `lat = 2`. Next cycle read x6 → `rd_stall = 1`, `issue_accept = 0`. Next cycle `res_data[1] = 0xAB` → `rd_data = 0xAB`, `rd_stall = 0`.
- Youngest wins: issue x7 = 1, then x7 = 2 in the following cycle; read x7 → 2. After both retire, the register file x7 = 2.
- Kill/hold:
  - x8 = 0x22 in stage 2 and x8 = 0x33 in stage 1; apply `kill_mask = 3'b010` → register file x8 = 0x22, and a read after retire = 0x22.
  - `hold` for 3 cycles → no register file write and no stage movement.
  - Issue x0 → `rd_data` of x0 stays 0.
- Without `NCORE_BYPASS_EN`: repeat the ALU forward scenario → `rd_stall = 1` for 3 cycles, then x5 = 0x11.
